// File: rtl/layer_pkg.sv
// layer_pkg: shared state, element types and weight indexing for the layer sequencer
package layer_pkg;
  localparam int WEIGHT_W = 9;
  localparam int RESULT_W = $clog2(1000);
  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic [RESULT_W-1:0] result_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic int unsigned widx(input int unsigned k, input int unsigned j, input int unsigned li);
    return k * li + j;
  endfunction
endpackage

// File: rtl/lat_pipe.sv
// lat_pipe: DEPTH-stage {valid, index} shift register tracking issues through the datapath
module lat_pipe #(
  parameter int DEPTH = 2,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [IW-1:0] idx,
  output logic          q_vld,
  output logic [IW-1:0] q_idx
);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0][IW-1:0] x;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      x <= '0;
    end else begin
      v[0] <= vld;
      x[0] <= idx;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        x[i] <= x[i-1];
      end
    end
  end
  assign q_vld = v[DEPTH-1];
  assign q_idx = x[DEPTH-1];
endmodule

// File: rtl/layer_seq.sv
// layer_seq: time-multiplexes one neuron datapath across all layer outputs.
// Defining LAYER_SEQ_PERF_EN adds a saturating busy-cycle counter (perf_cycles, perf_clr).
module layer_seq
  import layer_pkg::*;
#(
  parameter int LENGHT_I = 4,
  parameter int LENGHT_O = 2,
  parameter int WIDTH_W = WEIGHT_W,
  parameter int WIDTH_I = 1,
  parameter int RANGE_SIGM = 1000,
  parameter int WIDTH_O = $clog2(RANGE_SIGM),
  parameter int NEURON_LAT = 2,
  parameter int WADDR_W = $clog2(LENGHT_I*LENGHT_O)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_we,
  input  logic [WADDR_W-1:0]                w_addr,
  input  logic [WIDTH_W-1:0]                w_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LENGHT_I-1:0][WIDTH_I-1:0]  in,
  output logic                              n_valid,
  output logic [LENGHT_I-1:0][WIDTH_W-1:0]  n_w,
  output logic [LENGHT_I-1:0][WIDTH_I-1:0]  n_in,
  input  logic [WIDTH_O-1:0]                n_res,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LENGHT_O-1:0][WIDTH_O-1:0]  out,
`ifdef LAYER_SEQ_PERF_EN
  input  logic                              perf_clr,
  output logic [31:0]                       perf_cycles,
`endif
  output logic                              busy
);
  localparam int KW = $clog2(LENGHT_O+1);
  localparam int N = LENGHT_I*LENGHT_O;
  localparam logic [KW-1:0] K_LAST = KW'(LENGHT_O-1);
  state_t st, nxt;
  logic [KW-1:0] k, d_idx;
  logic d_vld;
  logic [WIDTH_W-1:0] mem [N];
  logic [LENGHT_I-1:0][WIDTH_I-1:0] in_q;
  assign in_ready = st == IDLE;
  assign n_valid = st == ISSUE;
  assign out_valid = st == DONE;
  assign busy = st != IDLE;
  assign n_in = n_valid ? in_q : '0;
  always_comb begin
    for (int j = 0; j < LENGHT_I; j++)
      n_w[j] = n_valid ? mem[WADDR_W'(widx(int'(k), j, LENGHT_I))] : '0;
  end
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = in_valid ? ISSUE : IDLE;
      ISSUE:   nxt = k == K_LAST ? DRAIN : ISSUE;
      DRAIN:   nxt = d_vld && d_idx == K_LAST ? DONE : DRAIN;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // the weight write lands on the same edge as the handshake, so the first issue sees it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      k <= '0;
      in_q <= '0;
      out <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      st <= nxt;
      if (w_we && st == IDLE && int'(w_addr) < N) mem[w_addr] <= w_data;
      if (in_valid && in_ready) begin
        in_q <= in;
        k <= '0;
      end else if (st == ISSUE && k != K_LAST) begin
        k <= k + KW'(1);
      end
      for (int i = 0; i < LENGHT_O; i++)
        if (d_vld && d_idx == KW'(i)) out[i] <= n_res;
    end
  end
  lat_pipe #(.DEPTH(NEURON_LAT), .IW(KW)) u_lat (
    .clk(clk),
    .rst(rst),
    .vld(n_valid),
    .idx(k),
    .q_vld(d_vld),
    .q_idx(d_idx)
  );
`ifdef LAYER_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_cycles <= '0;
    else if (perf_clr) perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: table-driven, directed and random checks of layer_seq against a behavioural layer model
module tb_layer_seq;
  localparam int LI = 4;
  localparam int LO = 2;
  localparam int NL = 2;
  localparam int WW = 9;
  localparam int WO = 10;
  logic clk = 0, rst = 1;
  logic w_we = 0;
  logic [2:0] w_addr = '0;
  logic [WW-1:0] w_data = '0;
  logic in_valid = 0, in_ready;
  logic [LI-1:0][0:0] vin = '0;
  logic n_valid;
  logic [LI-1:0][WW-1:0] n_w;
  logic [LI-1:0][0:0] n_in;
  logic [WO-1:0] n_res;
  logic out_valid, out_ready = 0, busy;
  logic [LO-1:0][WO-1:0] out;
`ifdef LAYER_SEQ_PERF_EN
  logic perf_clr = 0;
  logic [31:0] perf_cycles;
`endif
  int vecs = 0, errs = 0;
  int wm [LI*LO];
  int busy_edges = 0;
  logic [WO-1:0] dp [NL];
  typedef struct {logic [3:0] v; int e0; int e1;} vec_t;
  vec_t tbl [6];

  layer_seq dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in(vin),
    .n_valid(n_valid), .n_w(n_w), .n_in(n_in), .n_res(n_res),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
`ifdef LAYER_SEQ_PERF_EN
    .perf_clr(perf_clr), .perf_cycles(perf_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // datapath stand-in: masked weight sum, registered NL times, truncated
  always @(posedge clk) begin
    int s;
    s = 0;
    for (int j = 0; j < LI; j++) if (n_in[j][0]) s += int'($signed(n_w[j]));
    dp[0] <= s[WO-1:0];
    for (int i = 1; i < NL; i++) dp[i] <= dp[i-1];
  end
  assign n_res = dp[NL-1];
  always @(posedge clk) if (busy === 1'b1) busy_edges <= busy_edges + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int expect_out(input int k, input logic [3:0] v);
    int s = 0;
    for (int j = 0; j < LI; j++) if (v[j]) s += wm[k*LI+j];
    return s & ((1 << WO) - 1);
  endfunction

  function automatic int sext9(input int d);
    return d >= 256 ? d - 512 : d;
  endfunction

  task automatic wr(input int a, input int d);
    w_we = 1; w_addr = 3'(a); w_data = WW'(d);
    step;
    w_we = 0;
    wm[a] = sext9(d);
  endtask

  task automatic do_req(input logic [3:0] v, input int hold, input bit wissue, input bit wsame,
                        input int wa, input int wd, output int g0, output int g1);
    int e0, e1, c, nv, g;
    g = 0;
    while (!in_ready && g < 50) begin step; g++; end
    chk("in_ready_before_req", int'(in_ready), 1);
    if (wsame) begin
      w_we = 1; w_addr = 3'(wa); w_data = WW'(wd);
      wm[wa] = sext9(wd);
    end
    e0 = expect_out(0, v);
    e1 = expect_out(1, v);
    for (int j = 0; j < LI; j++) vin[j] = v[j];
    in_valid = 1;
    step;
    in_valid = 0; w_we = 0;
    if (wissue) begin w_we = 1; w_addr = 3'(wa); w_data = WW'(wd); end
    c = 1; nv = 0;
    while (!out_valid && c < 20) begin
      chk("n_valid_timing", int'(n_valid), int'(c <= LO));
      if (n_valid) begin
        nv++;
        for (int j = 0; j < LI; j++) chk("n_w_row", int'(n_w[j]), wm[(c-1)*LI+j] & 511);
      end else begin
        chk("n_w_idle_zero", int'(n_w), 0);
      end
      step;
      w_we = 0;
      c++;
    end
    chk("out_valid_latency", c, LO + NL + 1);
    chk("n_valid_count", nv, LO);
    chk("out0", int'(out[0]), e0);
    chk("out1", int'(out[1]), e1);
    in_valid = hold > 0;
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_n_valid", int'(n_valid), 0);
      chk("hold_out0", int'(out[0]), e0);
      chk("hold_out1", int'(out[1]), e1);
    end
    in_valid = 0;
    out_ready = 1;
    step;
    out_ready = 0;
    chk("return_idle", int'(in_ready), 1);
    chk("out_kept", int'(out[0]), e0);
    g0 = int'(out[0]);
    g1 = int'(out[1]);
  endtask

  initial begin
    int g0, g1, b0;
    tbl[0] = '{4'b1110, 9, 6};
    tbl[1] = '{4'b1111, 10, 11};
    tbl[2] = '{4'b0001, 1, 5};
    tbl[3] = '{4'b1000, 4, 3};
    tbl[4] = '{4'b0000, 0, 0};
    tbl[5] = '{4'b0101, 4, 7};
    for (int i = 0; i < LI*LO; i++) wm[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_n_valid", int'(n_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_n_in", int'(n_in), 0);

    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    wr(4, 5); wr(5, 1); wr(6, 2); wr(7, 3);
    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].v, 0, 0, 0, 0, 0, g0, g1);
      chk("tbl_out0", g0, tbl[i].e0);
      chk("tbl_out1", g1, tbl[i].e1);
    end

    do_req(4'b1110, 10, 0, 0, 0, 0, g0, g1);
    do_req(4'b0001, 0, 1, 0, 0, 7, g0, g1);
    chk("issue_write_ignored", g0, 1);
    do_req(4'b0001, 0, 0, 1, 4, 8, g0, g1);
    chk("same_cycle_write", g1, 8);

    for (int it = 0; it < 25; it++) begin
      logic [3:0] rv;
      rv = 4'($urandom_range(0, 15));
      wr($urandom_range(0, 7), $urandom_range(0, 511));
      wr($urandom_range(0, 7), $urandom_range(0, 511));
      do_req(rv, $urandom_range(0, 3), 0, 0, 0, 0, g0, g1);
    end

    for (int j = 0; j < LI; j++) vin[j] = 1'b1;
    in_valid = 1;
    step;
    in_valid = 0;
    step; step;
    chk("drain_busy", int'(busy), 1);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out", int'(out), 0);
    chk("arst_n_valid", int'(n_valid), 0);
    step;
    rst = 0;
    for (int i = 0; i < LI*LO; i++) wm[i] = 0;
    do_req(4'b1111, 0, 0, 0, 0, 0, g0, g1);
    chk("post_rst_out0", g0, 0);
    chk("post_rst_out1", g1, 0);

`ifdef LAYER_SEQ_PERF_EN
    perf_clr = 1;
    step;
    perf_clr = 0;
    chk("perf_cleared", int'(perf_cycles), 0);
    b0 = busy_edges;
    do_req(4'b0011, 0, 0, 0, 0, 0, g0, g1);
    chk("perf_busy_cycles", int'(perf_cycles), busy_edges - b0);
    perf_clr = 1;
    step;
    perf_clr = 0;
    chk("perf_clr", int'(perf_cycles), 0);
`else
    b0 = busy_edges;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
